// File: rtl/image_out_sram.sv
// Frame reader: streams one RGB565 frame from external SRAM, in ascending
// address order, to a downstream consumer over a valid/ready handshake.
// The SRAM strobes are driven only while a pixel read is in flight, and done
// pulses for one cycle once the last pixel has been accepted.
module image_out_sram #(
    parameter int unsigned PIXEL_COUNT = 76800,   // pixels per frame (320*240)
    parameter logic [18:0] BASE_ADDR   = 19'h0,   // SRAM word address of pixel 0
    parameter int unsigned READ_WAIT   = 1        // extra strobe cycles before sampling
) (
    input  logic        wclk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] sram_data_in,
    output logic        selec_out_sram,
    output logic        write_out_sram,
    output logic        read_out_sram,
    output logic [18:0] addr_rd_out_sram,
    output logic [15:0] pix_data,
    output logic [16:0] pix_addr,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic        done
);

    localparam int unsigned      CNT_W    = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_WAIT);
    localparam logic [16:0]      LAST_PIX = 17'(PIXEL_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_PRESENT,
        S_DONE,
        S_READY
    } state_t;

    state_t           state_q, state_d;
    logic             strobe_q, strobe_d;
    logic [18:0]      addr_q, addr_d;
    logic [16:0]      pix_addr_q, pix_addr_d;
    logic [15:0]      pix_data_q, pix_data_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Register the state and every output-facing value; reset clears them all.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge wclk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            strobe_q   <= 1'b0;
            addr_q     <= '0;
            pix_addr_q <= '0;
            pix_data_q <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            strobe_q   <= strobe_d;
            addr_q     <= addr_d;
            pix_addr_q <= pix_addr_d;
            pix_data_q <= pix_data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state and next-output decode for the frame-read sequence.
    // NOTE: every variable is given its hold value before the case statement,
    // so no path through the block leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        strobe_d   = strobe_q;
        addr_d     = addr_q;
        pix_addr_d = pix_addr_q;
        pix_data_d = pix_data_q;
        valid_d    = valid_q;
        done_d     = done_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE: begin
                strobe_d   = 1'b0;
                addr_d     = '0;
                pix_addr_d = '0;
                pix_data_d = '0;
                valid_d    = 1'b0;
                done_d     = 1'b0;
                if (enable) begin
                    addr_d   = BASE_ADDR;
                    strobe_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_READ;
                end
            end

            S_READ: begin
                // Strobes and address stay put until the SRAM has had
                // READ_WAIT+1 cycles to drive the data bus.
                if (cnt_q == CNT_LAST) begin
                    pix_data_d = sram_data_in;
                    valid_d    = 1'b1;
                    strobe_d   = 1'b0;
                    state_d    = S_PRESENT;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end

            S_PRESENT: begin
                // Hold the pixel until the consumer takes it.
                if (pix_ready) begin
                    valid_d = 1'b0;
                    if (pix_addr_q == LAST_PIX) begin
                        state_d = S_DONE;
                    end else begin
                        pix_addr_d = pix_addr_q + 17'd1;
                        addr_d     = addr_q + 19'd1;
                        strobe_d   = 1'b1;
                        cnt_d      = '0;
                        state_d    = S_READ;
                    end
                end
            end

            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_READY;
            end

            S_READY: begin
                // Clear the bus on the way out so idle shows all zeros.
                done_d     = 1'b0;
                addr_d     = '0;
                pix_addr_d = '0;
                pix_data_d = '0;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign selec_out_sram   = strobe_q;
    assign read_out_sram    = strobe_q;
    assign write_out_sram   = 1'b0;
    assign addr_rd_out_sram = addr_q;
    assign pix_addr         = pix_addr_q;
    assign pix_data         = pix_data_q;
    assign pix_valid        = valid_q;
    assign done             = done_q;
    assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_image_out_sram.sv
// Self-checking bench for image_out_sram: a small frame with a base address
// that wraps past 2^19, randomized backpressure and enable noise, a held
// stall, back-to-back frames and a mid-frame reset.
module tb_image_out_sram;

    localparam int          N    = 320;
    localparam logic [18:0] BASE = 19'h7FF00;
    localparam int          RW   = 1;

    logic        wclk;
    logic        rst;
    logic        enable;
    logic [15:0] sram_data_in;
    logic        selec_out_sram;
    logic        write_out_sram;
    logic        read_out_sram;
    logic [18:0] addr_rd_out_sram;
    logic [15:0] pix_data;
    logic [16:0] pix_addr;
    logic        pix_valid;
    logic        pix_ready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    image_out_sram #(
        .PIXEL_COUNT (N),
        .BASE_ADDR   (BASE),
        .READ_WAIT   (RW)
    ) dut (
        .wclk             (wclk),
        .rst              (rst),
        .enable           (enable),
        .sram_data_in     (sram_data_in),
        .selec_out_sram   (selec_out_sram),
        .write_out_sram   (write_out_sram),
        .read_out_sram    (read_out_sram),
        .addr_rd_out_sram (addr_rd_out_sram),
        .pix_data         (pix_data),
        .pix_addr         (pix_addr),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .busy             (busy),
        .done             (done)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Content of an SRAM word as a function of its address.
    function automatic logic [15:0] sram_word(input logic [18:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    // SRAM word address of pixel i, wrapping modulo 2^19.
    function automatic logic [18:0] exp_addr(input int i);
        return BASE + 19'(i);
    endfunction

    // The SRAM only drives meaningful data while selected for a read.
    always_comb begin
        sram_data_in = 16'hDEAD;
        if (selec_out_sram && read_out_sram)
            sram_data_in = sram_word(addr_rd_out_sram);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge wclk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check(tag, 64'({selec_out_sram, write_out_sram, read_out_sram, addr_rd_out_sram,
                        pix_data, pix_addr, pix_valid, busy, done}), 64'd0);
    endtask

    // Run one frame. ready_pct: chance of pix_ready per cycle; stall_idx: pixel
    // held off for 20 cycles (-1 = none); restart: keep enable high at the end.
    task automatic run_frame(input int ready_pct, input int stall_idx, input bit restart);
        int idx        = 0;
        int cyc        = 0;
        int start_cyc  = 0;
        int stall_left = 20;
        int budget     = 30 * N + 100;
        bit shown      = 1'b0;
        bit xfer       = 1'b0;

        enable    = 1'b1;
        pix_ready = 1'b0;
        tick();
        while (1) begin
            if (xfer) begin
                xfer      = 1'b0;
                idx++;
                start_cyc = cyc;
            end
            if (idx == N || cyc >= budget) break;

            check("write_strobe", 64'(write_out_sram), 64'd0);
            check("selec_eq_read", 64'(selec_out_sram), 64'(read_out_sram));
            check("busy_mid", 64'(busy), 64'd1);
            check("done_mid", 64'(done), 64'd0);
            check("no_gap", 64'(read_out_sram | pix_valid), 64'd1);

            if (read_out_sram) begin
                check("rd_addr", 64'(addr_rd_out_sram), 64'(exp_addr(idx)));
                check("valid_during_read", 64'(pix_valid), 64'd0);
            end

            if (pix_valid) begin
                check("pix_addr", 64'(pix_addr), 64'(idx));
                check("pix_data", 64'(pix_data), 64'(sram_word(exp_addr(idx))));
                if (!shown) begin
                    check("read_latency", 64'(cyc - start_cyc), 64'(RW + 1));
                    shown = 1'b1;
                end
                if (idx == stall_idx && stall_left > 0) begin
                    pix_ready = 1'b0;
                    stall_left--;
                end else begin
                    pix_ready = (int'($urandom_range(99)) < ready_pct);
                end
                xfer = pix_ready;
                if (xfer) shown = 1'b0;
            end else begin
                pix_ready = 1'($urandom_range(1));
            end

            enable = 1'($urandom_range(1));
            tick();
            cyc++;
        end

        check("frame_complete", 64'(idx), 64'(N));

        // State right after the last transfer edge.
        enable    = restart;
        pix_ready = 1'($urandom_range(1));
        check("end_done_low", 64'(done), 64'd0);
        check("end_busy", 64'(busy), 64'd1);
        check("end_valid", 64'(pix_valid), 64'd0);
        check("end_strobe", 64'(read_out_sram), 64'd0);
        check("last_pix_addr", 64'(pix_addr), 64'(N - 1));
        check("last_sram_addr", 64'(addr_rd_out_sram), 64'(exp_addr(N - 1)));
        tick();
        check("done_pulse", 64'(done), 64'd1);
        check("done_busy", 64'(busy), 64'd1);
        check("done_strobe", 64'(read_out_sram), 64'd0);
        tick();
        check("done_clear", 64'(done), 64'd0);
        check_idle("back_to_idle");
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        pix_ready = 1'b0;

        // Reset and quiet idle.
        repeat (3) tick();
        check_idle("reset_state");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_idle("idle_no_enable");
        end

        // Full ready with a 20-cycle stall on pixel 5.
        run_frame(100, 5, 1'b0);
        repeat (2) begin
            tick();
            check_idle("idle_between");
        end

        // Random backpressure; enable left high so the next frame follows.
        run_frame(50, -1, 1'b1);
        run_frame(30, -1, 1'b0);

        // Reset during the read of pixel 100.
        enable    = 1'b1;
        pix_ready = 1'b1;
        tick();
        enable = 1'b0;
        repeat (100 * (RW + 2)) tick();
        check("abort_in_read", 64'(read_out_sram), 64'd1);
        check("abort_pix_addr", 64'(pix_addr), 64'd100);
        check("abort_sram_addr", 64'(addr_rd_out_sram), 64'(exp_addr(100)));
        rst = 1'b1;
        tick();
        check_idle("abort_cleared");
        rst = 1'b0;
        repeat (3) begin
            tick();
            check_idle("abort_idle");
        end

        // Next frame must restart from pixel 0 at the base address.
        run_frame(100, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
